pipe_delay_line: RTL and testbench

//  Parametrised multi-stage delay line with stall and flush. Carries a WIDTH-bit

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_stage_reg.sv | 49 ++++
 rtl/pipe_delay_line.sv | 84 ++++++++
 tb/tb_pipe_delay_line.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Purpose : shared sizing helpers and limits for the pipe_delay_line family.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   PIPE_DEPTH_MAX  largest DEPTH accepted at elaboration
//   clog2_cnt()     width of a counter able to hold 0..depth inclusive
package pipe_pkg;

    localparam int PIPE_DEPTH_MAX = 16;

    // Bits needed to represent the values 0..depth. A full line holds
    // `depth` valid stages, so the count must reach depth itself, not depth-1.
    // depth=1 yields 1 bit, depth=3 yields 2 bits, depth=4 yields 3 bits.
    function automatic int clog2_cnt(input int depth);
        int w;
        w = 1;
        while ((1 << w) < (depth + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// Purpose : one register stage of {valid, payload} for the delay line.
// Latency : 1 enabled clock from d_* to q_*.
// Backpressure: enable=0 holds the stage; flush clears valid only, payload follows enable.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset to {0, RESET_VAL}
//   enable              1 = load d_* this edge, 0 = hold
//   flush               1 = force q_valid to 0 (takes priority over enable for valid)
//   d_valid, d_data     value presented by the previous stage (or the line input)
//   q_valid, q_data     registered stage contents
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    // Payload moves whenever the line advances, even during a flush, so the
    // contents of invalid stages stay deterministic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_data <= RESET_VAL;
        end else if (enable) begin
            q_data <= d_data;
        end
    end

    // Valid is cleared by flush regardless of enable; otherwise it shifts
    // with the payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_valid <= 1'b0;
        end else if (flush) begin
            q_valid <= 1'b0;
        end else if (enable) begin
            q_valid <= d_valid;
        end
    end

endmodule : pipe_stage_reg

// File: rtl/pipe_delay_line.sv
// Purpose : DEPTH-stage {valid, payload} delay line with stall, flush and a live valid count.
// Latency : exactly DEPTH enabled clocks from in_* to out_*; stalled cycles only add delay.
// Backpressure: enable=0 stalls every stage (inputs ignored); flush=1 turns all stages into bubbles.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   enable              1 = advance the line one stage, 0 = hold everything
//   flush               1 = clear every valid bit (payloads still follow enable)
//   in_valid, in_data   token entering stage 0
//   out_valid, out_data contents of the last stage (registered)
//   stage_vld           valid bit of every stage, bit i = stage i (registered)
//   count               number of valid stages, kept as its own register
module pipe_delay_line
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = clog2_cnt(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [DEPTH-1:0] stage_vld,
    output logic [CW-1:0]    count
);

    // Reject parameter sets the line was never meant to support.
    if (DEPTH < 1 || DEPTH > PIPE_DEPTH_MAX || WIDTH < 1) begin : g_bad_params
        $error("pipe_delay_line: need 1 <= DEPTH <= %0d and WIDTH >= 1 (DEPTH=%0d WIDTH=%0d)",
               PIPE_DEPTH_MAX, DEPTH, WIDTH);
    end

    // Chain index 0 is the line input; index i+1 is the output of stage i.
    logic [DEPTH:0]   v_chain;
    logic [WIDTH-1:0] d_chain [0:DEPTH];

    assign v_chain[0] = in_valid;
    assign d_chain[0] = in_data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        pipe_stage_reg #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .enable  (enable),
            .flush   (flush),
            .d_valid (v_chain[i]),
            .d_data  (d_chain[i]),
            .q_valid (v_chain[i+1]),
            .q_data  (d_chain[i+1])
        );
    end

    assign stage_vld = v_chain[DEPTH:1];
    assign out_valid = v_chain[DEPTH];
    assign out_data  = d_chain[DEPTH];

    // Incremental occupancy: +1 for a token entering, -1 for the one leaving
    // the last stage. The subtraction cannot wrap because a valid last stage
    // implies count >= 1, and the sum cannot pass DEPTH because an entering
    // token into a full line is always matched by one leaving.
    logic [CW-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CW'(in_valid) - CW'(v_chain[DEPTH]);
        end
    end

    assign count = count_q;

endmodule : pipe_delay_line

// File: tb/tb_pipe_delay_line.sv
module tb_pipe_delay_line;

    logic       clk;
    logic       reset;

    // Main instance: WIDTH=8, DEPTH=3, RESET_VAL=8'hA5
    logic       en, fl, iv;
    logic [7:0] id;
    logic       ov;
    logic [7:0] od;
    logic [2:0] sv;
    logic [1:0] cnt;

    // Corner instance: WIDTH=1, DEPTH=1
    logic       en1, fl1, iv1;
    logic [0:0] id1;
    logic       ov1;
    logic [0:0] od1;
    logic [0:0] sv1;
    logic [0:0] cnt1;

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_delay_line #(
        .WIDTH     (8),
        .DEPTH     (3),
        .RESET_VAL (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (en),
        .flush     (fl),
        .in_valid  (iv),
        .in_data   (id),
        .out_valid (ov),
        .out_data  (od),
        .stage_vld (sv),
        .count     (cnt)
    );

    pipe_delay_line #(
        .WIDTH     (1),
        .DEPTH     (1),
        .RESET_VAL (1'b1)
    ) dut1 (
        .clk       (clk),
        .reset     (reset),
        .enable    (en1),
        .flush     (fl1),
        .in_valid  (iv1),
        .in_data   (id1),
        .out_valid (ov1),
        .out_data  (od1),
        .stage_vld (sv1),
        .count     (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: each in-flight token with the number of enabled edges it
    // has seen. A token is at the output once its age equals the depth.
    typedef struct {
        logic [7:0] d;
        int         age;
    } tok_t;
    typedef tok_t tokq_t[$];

    tokq_t q3;
    tokq_t q1;

    task automatic model_adv(input tokq_t qi, input int depth, input logic e, input logic f,
                             input logic v, input logic [7:0] d, output tokq_t qo);
        qo = qi;
        if (f) begin
            qo.delete();
        end else if (e) begin
            if (qo.size() > 0 && qo[0].age == depth) qo.delete(0);
            foreach (qo[k]) qo[k].age = qo[k].age + 1;
            if (v) qo.push_back('{d: d, age: 1});
        end
    endtask

    function automatic logic [2:0] model_mask(input tokq_t q);
        logic [2:0] m;
        m = '0;
        foreach (q[k]) m[q[k].age-1] = 1'b1;
        return m;
    endfunction

    // Directed table: inputs applied at a negedge, results checked at the next negedge.
    typedef struct {
        logic       en, fl, iv;
        logic [7:0] id;
        logic       ov;
        logic [7:0] od;
        logic       od_chk;
        logic [2:0] sv;
        logic [1:0] cnt;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    initial begin
        // en fl iv id      ov od    chk sv      cnt
        // fill 11,22,33
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 3'b001, 2'd1};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 3'b011, 2'd2};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 8'h11, 1'b1, 3'b111, 2'd3};
        // stall 4 cycles with toggling inputs
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 8'h11, 1'b1, 3'b111, 2'd3};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 8'h11, 1'b1, 3'b111, 2'd3};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h11, 1'b1, 3'b111, 2'd3};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 3'b111, 2'd3};
        // drain
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 3'b110, 2'd2};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 3'b100, 2'd1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'b000, 2'd0};
        // refill 01,02,03 then simultaneous enter/exit keeps count at 3
        tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 3'b001, 2'd1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 3'b011, 2'd2};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 8'h01, 1'b1, 3'b111, 2'd3};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 8'h02, 1'b1, 3'b111, 2'd3};
        // flush with enable: payload still shifts, 44 enters as a bubble
        tbl[14] = '{1'b1, 1'b1, 1'b1, 8'h44, 1'b0, 8'h03, 1'b1, 3'b000, 2'd0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 3'b000, 2'd0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h44, 1'b1, 3'b000, 2'd0};
        // refill 55,66,77 then flush without enable: payloads hold
        tbl[17] = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 3'b001, 2'd1};
        tbl[18] = '{1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 3'b011, 2'd2};
        tbl[19] = '{1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 8'h55, 1'b1, 3'b111, 2'd3};
        tbl[20] = '{1'b0, 1'b1, 1'b1, 8'h88, 1'b0, 8'h55, 1'b1, 3'b000, 2'd0};
        tbl[21] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h66, 1'b1, 3'b000, 2'd0};
        tbl[22] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h77, 1'b1, 3'b000, 2'd0};
    end

    initial begin
        en = 1'b0; fl = 1'b0; iv = 1'b0; id = 8'h00;
        en1 = 1'b0; fl1 = 1'b0; iv1 = 1'b0; id1 = 1'b0;
        reset = 1'b0;

        // 1. Reset pulse before the first clock edge
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst_ov",  32'(ov),  32'(1'b0));
        check("rst_od",  32'(od),  32'(8'hA5));
        check("rst_sv",  32'(sv),  32'(3'b000));
        check("rst_cnt", 32'(cnt), 32'(2'd0));
        check("rst1_od", 32'(od1), 32'(1'b1));
        check("rst1_ov", 32'(ov1), 32'(1'b0));

        @(negedge clk);

        // 2-4. Directed table
        for (int i = 0; i < NV; i++) begin
            en = tbl[i].en; fl = tbl[i].fl; iv = tbl[i].iv; id = tbl[i].id;
            @(negedge clk);
            check($sformatf("vec%0d_ov", i),  32'(ov),  32'(tbl[i].ov));
            if (tbl[i].od_chk) check($sformatf("vec%0d_od", i), 32'(od), 32'(tbl[i].od));
            check($sformatf("vec%0d_sv", i),  32'(sv),  32'(tbl[i].sv));
            check($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(tbl[i].cnt));
        end

        // 5. Asynchronous reset between edges with two tokens in flight
        en = 1'b1; fl = 1'b0; iv = 1'b1; id = 8'hC1;
        @(negedge clk);
        id = 8'hC2;
        @(negedge clk);
        en = 1'b0; iv = 1'b0;
        check("pre_arst_cnt", 32'(cnt), 32'(2'd2));
        #2 reset = 1'b1;
        #1;
        check("arst_cnt", 32'(cnt), 32'(2'd0));
        check("arst_od",  32'(od),  32'(8'hA5));
        check("arst_ov",  32'(ov),  32'(1'b0));
        check("arst_sv",  32'(sv),  32'(3'b000));
        @(negedge clk);
        reset = 1'b0;
        en = 1'b1; iv = 1'b1; id = 8'h99;
        @(negedge clk);
        en = 1'b0; iv = 1'b0;
        check("post_arst_sv",  32'(sv),  32'(3'b001));
        check("post_arst_cnt", 32'(cnt), 32'(2'd1));
        check("post_arst_od",  32'(od),  32'(8'hA5));

        // 6. Random traffic on both instances against the scoreboard
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        q3.delete();
        q1.delete();
        @(negedge clk);
        for (int c = 0; c < 2000; c++) begin
            check("rnd_ov",  32'(ov),  32'(q3.size() > 0 && q3[0].age == 3));
            if (q3.size() > 0 && q3[0].age == 3) check("rnd_od", 32'(od), 32'(q3[0].d));
            check("rnd_sv",  32'(sv),  32'(model_mask(q3)));
            check("rnd_cnt", 32'(cnt), 32'(q3.size()));
            check("rnd_pop", 32'(cnt), 32'($countones(sv)));

            check("rnd1_ov",  32'(ov1),  32'(q1.size() > 0 && q1[0].age == 1));
            if (q1.size() > 0 && q1[0].age == 1) check("rnd1_od", 32'(od1), 32'(q1[0].d));
            check("rnd1_cnt", 32'(cnt1), 32'(q1.size()));
            check("rnd1_pop", 32'(cnt1), 32'($countones(sv1)));

            en  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 11) == 0);
            iv  = 1'($urandom_range(0, 1));
            id  = 8'($urandom);
            en1 = ($urandom_range(0, 2) != 0);
            fl1 = ($urandom_range(0, 9) == 0);
            iv1 = 1'($urandom_range(0, 1));
            id1 = 1'($urandom_range(0, 1));
            model_adv(q3, 3, en, fl, iv, id, q3);
            model_adv(q1, 1, en1, fl1, iv1, {7'd0, id1}, q1);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pipe_delay_line
